// File: rtl/boot_arbiter_pkg.sv
// Shared types and sizes for the boot arbiter: state encoding and bus widths.
package boot_arbiter_pkg;

  localparam int INSTR_W    = 15;
  localparam int ADR_W      = 8;
  localparam int IMEM_DEPTH = 256;
  localparam int CORE_DW    = 8;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_e;

endpackage

// File: rtl/boot_arbiter_if.sv
// Loader, core and shared-memory signals of the boot arbiter.
//
// Loader handshake: a word moves only in a cycle where ld_valid and ld_ready
// are both high. ld_ready is combinational from the arbiter state and the
// current ld_start/reset inputs; ld_valid may be raised regardless of ld_ready
// and the word is simply not taken until ld_ready is also high. ld_last is
// looked at only in a cycle where the word moves.
interface boot_arbiter_if;
  import boot_arbiter_pkg::*;

  logic               ld_start;
  logic               ld_valid;
  logic               ld_last;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_ready;

  logic [ADR_W-1:0]   core_adr;
  logic               core_memwrite;
  logic [CORE_DW-1:0] core_wdata;

  logic [ADR_W-1:0]   mem_adr;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_wdata;

  // Arbiter side
  modport slave (
    input  ld_start, ld_valid, ld_last, ld_data,
    input  core_adr, core_memwrite, core_wdata,
    output ld_ready, mem_adr, mem_we, mem_wdata
  );

  // Loader / core / memory side
  modport master (
    output ld_start, ld_valid, ld_last, ld_data,
    output core_adr, core_memwrite, core_wdata,
    input  ld_ready, mem_adr, mem_we, mem_wdata
  );

endinterface

// File: rtl/boot_arbiter_ld_counter.sv
// Load address counter: 8-bit, enabled increment, synchronous clear that
// wins over the enable, and a wrap flag for an increment taken at the top.
module ld_counter
  import boot_arbiter_pkg::*;
(
  input  logic             ph1,
  input  logic             ph2,
  input  logic             clr,
  input  logic             en,
  output logic [ADR_W-1:0] count,
  output logic             wrap
);

  logic [ADR_W-1:0] count_d;
  logic [ADR_W-1:0] count_m;
  logic [ADR_W-1:0] count_q;

  // Next count: clear has priority, otherwise step by one when enabled
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + ADR_W'(1);
    end
  end

  // ph2 captures the next count into the master stage
  always_ff @(posedge ph2) begin
    count_m <= count_d;
  end

  // ph1 launches the captured count to the output stage
  always_ff @(posedge ph1) begin
    count_q <= count_m;
  end

  assign count = count_q;
  assign wrap  = en & ~clr & (count_q == ADR_W'(IMEM_DEPTH - 1));

endmodule

// File: rtl/boot_arbiter.sv
// Boot arbiter: owns the shared instruction memory while a program is loaded,
// holds the core in reset until the load finishes (or run_en bypasses it),
// then hands the memory port to the core.
module boot_arbiter
  import boot_arbiter_pkg::*;
(
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             run_en,
  boot_arbiter_if.slave    bus,
  output logic             core_reset,
  output logic [ADR_W-1:0] ld_count,
  output logic             ld_ovf,
  output logic             running,
  output state_e           dbg_state
);

  state_e state_d, state_m, state_q;
  logic   ovf_d, ovf_m, ovf_q;
  logic   running_d, running_m, running_q;
  logic   core_reset_d, core_reset_m, core_reset_q;

  logic   ld_ready;
  logic   xfer;
  logic   cnt_clr;
  logic   cnt_wrap;

  // ld_start takes priority over a word, and reset drops any word in flight
  assign ld_ready     = (state_q == LOAD) & ~bus.ld_start & ~reset;
  assign bus.ld_ready = ld_ready;
  assign xfer         = ld_ready & bus.ld_valid;

  // A load (re)start rewinds to address 0, except in RELEASE where it is ignored
  assign cnt_clr = reset | (bus.ld_start & (state_q != RELEASE));

  ld_counter u_ld_counter (
    .ph1   (ph1),
    .ph2   (ph2),
    .clr   (cnt_clr),
    .en    (xfer),
    .count (ld_count),
    .wrap  (cnt_wrap)
  );

  // Next state, overflow flag and registered status outputs
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = BOOT;
    end else begin
      case (state_q)
        BOOT: begin
          if (bus.ld_start)  state_d = LOAD;
          else if (run_en)   state_d = RELEASE;
        end
        LOAD: begin
          if (xfer && (bus.ld_last || cnt_wrap)) state_d = RELEASE;
        end
        RELEASE: state_d = RUN;
        RUN: begin
          if (bus.ld_start) state_d = LOAD;
        end
        default: state_d = BOOT;
      endcase
    end

    ovf_d = ovf_q;
    if (cnt_clr) begin
      ovf_d = 1'b0;
    end else if (cnt_wrap && !bus.ld_last) begin
      ovf_d = 1'b1;
    end

    running_d    = (state_d == RUN);
    core_reset_d = (state_d != RUN);
  end

  // ph2 captures next state into the master stage
  always_ff @(posedge ph2) begin
    state_m      <= state_d;
    ovf_m        <= ovf_d;
    running_m    <= running_d;
    core_reset_m <= core_reset_d;
  end

  // ph1 launches the captured state to the outputs
  always_ff @(posedge ph1) begin
    state_q      <= state_m;
    ovf_q        <= ovf_m;
    running_q    <= running_m;
    core_reset_q <= core_reset_m;
  end

  // Shared memory port: loader in LOAD, core in RUN, parked otherwise
  always_comb begin
    bus.mem_adr   = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      LOAD: begin
        bus.mem_adr   = ld_count;
        bus.mem_we    = xfer;
        bus.mem_wdata = bus.ld_data;
      end
      RUN: begin
        bus.mem_adr   = bus.core_adr;
        bus.mem_we    = bus.core_memwrite & ~reset;
        bus.mem_wdata = {{(INSTR_W - CORE_DW){1'b0}}, bus.core_wdata};
      end
      default: ;
    endcase
  end

  assign ld_ovf     = ovf_q;
  assign running    = running_q;
  assign core_reset = core_reset_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_boot_arbiter.sv
// Bench for boot_arbiter: directed scenarios with literal checks plus random
// traffic, all compared cycle by cycle against a rule-level model.
module tb_boot_arbiter;
  import boot_arbiter_pkg::*;

  logic             ph1 = 1'b0;
  logic             ph2 = 1'b0;
  logic             reset = 1'b1;
  logic             run_en = 1'b0;
  logic             core_reset;
  logic [ADR_W-1:0] ld_count;
  logic             ld_ovf;
  logic             running;
  state_e           dbg_state;

  boot_arbiter_if bus ();

  boot_arbiter dut (
    .ph1        (ph1),
    .ph2        (ph2),
    .reset      (reset),
    .run_en     (run_en),
    .bus        (bus),
    .core_reset (core_reset),
    .ld_count   (ld_count),
    .ld_ovf     (ld_ovf),
    .running    (running),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  // One cycle: ph1 high, gap, ph2 high, gap. Inputs change after ph1 falls,
  // outputs are sampled before ph2 rises.
  initial begin
    forever begin
      #5 ph1 = 1'b1;
      #5 ph1 = 1'b0;
      #5 ph2 = 1'b1;
      #5 ph2 = 1'b0;
    end
  end

  // ---------------- counters / check ----------------
  int n_vec  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;
  logic [ADR_W+INSTR_W-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit rst, input bit ren, input bit st, input bit v,
                     input bit last, input logic [INSTR_W-1:0] d,
                     input logic [7:0] ca, input bit cw, input logic [7:0] cd);
    @(negedge ph1);
    reset             = rst;
    run_en            = ren;
    bus.ld_start      = st;
    bus.ld_valid      = v;
    bus.ld_last       = last;
    bus.ld_data       = d;
    bus.core_adr      = ca;
    bus.core_memwrite = cw;
    bus.core_wdata    = cd;
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic start();
    cyc(0, 0, 1, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic word(input logic [INSTR_W-1:0] d, input bit last);
    cyc(0, 0, 0, 1, last, d, '0, 0, '0);
  endtask

  // ---------------- behavioural model + compare ----------------
  localparam int M_BOOT = 0, M_LOAD = 1, M_REL = 2, M_RUN = 3;
  int m_st  = M_BOOT;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  function automatic state_e name_of(input int s);
    case (s)
      M_LOAD:  return LOAD;
      M_REL:   return RELEASE;
      M_RUN:   return RUN;
      default: return BOOT;
    endcase
  endfunction

  bit               e_rdy, e_x, e_we;
  int               e_adr;
  logic [INSTR_W-1:0] e_wd;

  initial begin
    forever begin
      @(negedge ph1);
      #3;
      e_rdy = (m_st == M_LOAD) && !bus.ld_start && !reset;
      e_x   = e_rdy && bus.ld_valid;
      e_we  = (m_st == M_RUN) ? (bus.core_memwrite && !reset) : e_x;
      e_adr = (m_st == M_LOAD) ? m_cnt : (m_st == M_RUN) ? int'(bus.core_adr) : 0;
      e_wd  = (m_st == M_LOAD) ? bus.ld_data :
              (m_st == M_RUN)  ? INSTR_W'(bus.core_wdata) : '0;
      if (chk_en) begin
        chk("state",      32'(dbg_state),    32'(name_of(m_st)));
        chk("ld_ready",   32'(bus.ld_ready), 32'(e_rdy));
        chk("mem_we",     32'(bus.mem_we),   32'(e_we));
        chk("mem_adr",    32'(bus.mem_adr),  32'(e_adr));
        if (m_st != M_LOAD || e_x) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
        chk("core_reset", 32'(core_reset),   32'(m_st != M_RUN));
        chk("running",    32'(running),      32'(m_st == M_RUN));
        chk("ld_count",   32'(ld_count),     32'(m_cnt));
        chk("ld_ovf",     32'(ld_ovf),       32'(m_ovf));
        if (e_we) exp_q.push_back({8'(e_adr), e_wd});
        if (bus.mem_we === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wr_sb: got write adr 0x%0h, expected no write", bus.mem_adr);
          end else begin
            chk("wr_sb", 32'({bus.mem_adr, bus.mem_wdata}), 32'(exp_q.pop_front()));
          end
        end
      end
      // advance the model by one cycle using the rules
      if (reset) begin
        m_st = M_BOOT; m_cnt = 0; m_ovf = 1'b0;
      end else if (bus.ld_start && m_st != M_REL) begin
        m_st = M_LOAD; m_cnt = 0; m_ovf = 1'b0;
      end else begin
        case (m_st)
          M_BOOT: if (run_en) m_st = M_REL;
          M_LOAD: if (e_x) begin
            if (!bus.ld_last && m_cnt == IMEM_DEPTH - 1) m_ovf = 1'b1;
            if (bus.ld_last || m_cnt == IMEM_DEPTH - 1) m_st = M_REL;
            m_cnt = (m_cnt + 1) % IMEM_DEPTH;
          end
          M_REL:  m_st = M_RUN;
          default: ;
        endcase
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_last = 0; bus.ld_data = '0;
    bus.core_adr = '0; bus.core_memwrite = 0; bus.core_wdata = '0;

    cyc(1, 0, 0, 0, 0, '0, '0, 0, '0);
    cyc(1, 0, 1, 1, 0, 15'h1111, 8'h22, 1, 8'h33);
    chk_en = 1'b1;

    // reset state
    idle();
    chk("rst_state", 32'(dbg_state), 32'(BOOT));
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_count", 32'(ld_count), 32'd0);
    chk("rst_ovf", 32'(ld_ovf), 32'd0);
    chk("rst_ready", 32'(bus.ld_ready), 32'd0);

    // core write attempt in BOOT is ignored
    cyc(0, 0, 0, 0, 0, '0, 8'h3C, 1, 8'hA5);
    chk("boot_mux_we", 32'(bus.mem_we), 32'd0);
    chk("boot_mux_adr", 32'(bus.mem_adr), 32'd0);

    // load-then-run
    start();
    word(15'h1234, 0);
    chk("l3_w0_adr", 32'(bus.mem_adr), 32'd0);
    chk("l3_w0_dat", 32'(bus.mem_wdata), 32'h1234);
    chk("l3_w0_we", 32'(bus.mem_we), 32'd1);
    word(15'h0055, 0);
    chk("l3_w1_adr", 32'(bus.mem_adr), 32'd1);
    chk("l3_w1_dat", 32'(bus.mem_wdata), 32'h0055);
    word(15'h7FFF, 1);
    chk("l3_w2_adr", 32'(bus.mem_adr), 32'd2);
    chk("l3_w2_dat", 32'(bus.mem_wdata), 32'h7FFF);
    idle();
    chk("l3_release", 32'(dbg_state), 32'(RELEASE));
    chk("l3_rel_core_reset", 32'(core_reset), 32'd1);
    idle();
    chk("l3_run", 32'(dbg_state), 32'(RUN));
    chk("l3_core_reset", 32'(core_reset), 32'd0);
    chk("l3_count", 32'(ld_count), 32'd3);
    chk("l3_running", 32'(running), 32'd1);

    // run mux
    cyc(0, 0, 0, 0, 0, '0, 8'h3C, 1, 8'hA5);
    chk("run_adr", 32'(bus.mem_adr), 32'h3C);
    chk("run_we", 32'(bus.mem_we), 32'd1);
    chk("run_wdata", 32'(bus.mem_wdata), 32'h00A5);

    // reload from RUN, then reset mid-load
    start();
    word(15'h0101, 0);
    chk("rl_state", 32'(dbg_state), 32'(LOAD));
    chk("rl_core_reset", 32'(core_reset), 32'd1);
    chk("rl_ovf", 32'(ld_ovf), 32'd0);
    chk("rl_adr", 32'(bus.mem_adr), 32'd0);
    word(15'h0202, 0);
    cyc(1, 0, 0, 1, 0, 15'h0303, '0, 0, '0);
    chk("rl_rst_we", 32'(bus.mem_we), 32'd0);
    chk("rl_rst_ready", 32'(bus.ld_ready), 32'd0);
    idle();
    chk("rl_boot", 32'(dbg_state), 32'(BOOT));
    chk("rl_count", 32'(ld_count), 32'd0);

    // backpressure: ld_start together with a valid word
    start();
    cyc(0, 0, 1, 1, 0, 15'h0AAA, '0, 0, '0);
    chk("bp_ready", 32'(bus.ld_ready), 32'd0);
    chk("bp_we", 32'(bus.mem_we), 32'd0);
    chk("bp_count", 32'(ld_count), 32'd0);
    word(15'h0BBB, 0);
    chk("bp_adr", 32'(bus.mem_adr), 32'd0);
    chk("bp_we2", 32'(bus.mem_we), 32'd1);
    chk("bp_dat", 32'(bus.mem_wdata), 32'h0BBB);
    start();
    idle();
    chk("restart_count", 32'(ld_count), 32'd0);

    // overflow: 256 words with no ld_last
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      word(15'(i) ^ 15'h5A5A, 0);
      if (i == IMEM_DEPTH - 1) begin
        chk("ovf_last_adr", 32'(bus.mem_adr), 32'd255);
        chk("ovf_last_we", 32'(bus.mem_we), 32'd1);
      end
    end
    start();
    chk("ovf_release", 32'(dbg_state), 32'(RELEASE));
    chk("ovf_flag", 32'(ld_ovf), 32'd1);
    chk("ovf_count", 32'(ld_count), 32'd0);
    idle();
    chk("ovf_run", 32'(dbg_state), 32'(RUN));
    chk("ovf_sticky", 32'(ld_ovf), 32'd1);
    start();
    idle();
    chk("ovf_clear", 32'(ld_ovf), 32'd0);
    chk("ovf_reload", 32'(dbg_state), 32'(LOAD));

    // bypass with run_en
    cyc(1, 0, 0, 0, 0, '0, '0, 0, '0);
    cyc(0, 1, 0, 0, 0, '0, '0, 0, '0);
    idle();
    chk("byp_release", 32'(dbg_state), 32'(RELEASE));
    idle();
    chk("byp_run", 32'(dbg_state), 32'(RUN));
    chk("byp_count", 32'(ld_count), 32'd0);
    chk("byp_core_reset", 32'(core_reset), 32'd0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0, 15'($urandom), 8'($urandom),
          $urandom_range(0, 1) == 1, 8'($urandom));
    end
    idle();
    idle();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boot_arbiter.md
BOOT_ARBITER -- requirements
Module: boot_arbiter

Interface
REQ-001 SHALL have a single two-phase clock and one reset. Reset SHALL be synchronous and active-high.
REQ-002 ph1  in  1  launch phase of the single clock; registered outputs update while high.
REQ-003 ph2  in  1  capture phase of the same clock; next-state and reset are sampled while high.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 run_en  in  1  level; permits BOOT->RELEASE without a load.
REQ-006 ld_start  in  1  one-cycle pulse; begins or restarts a program load at address 0.
REQ-007 ld_valid  in  1  loader word valid.
REQ-008 ld_last  in  1  qualifies the final word; meaningful only with ld_valid.
REQ-009 ld_data  in  15  instruction word; bits [14:8] high part, bits [7:0] low part.
REQ-010 ld_ready  out  1  arbiter accepts a word this cycle.
REQ-011 core_adr  in  8  core memory address.
REQ-012 core_memwrite  in  1  core write strobe.
REQ-013 core_wdata  in  8  core store data.
REQ-014 core_reset  out  1  reset driven to the core.
REQ-015 mem_adr  out  8  shared memory address.
REQ-016 mem_we  out  1  shared memory write enable.
REQ-017 mem_wdata  out  15  shared memory write data.
REQ-018 ld_count  out  8  next load address (number of words written).
REQ-019 ld_ovf  out  1  sticky flag; a load wrapped past address 255.
REQ-020 running  out  1  high in the RUN state.

Function
REQ-021 States SHALL be BOOT, LOAD, RELEASE and RUN. Exactly one state update SHALL occur per clock cycle.
REQ-022 BOOT transitions: ld_start -> LOAD. Otherwise run_en -> RELEASE. Otherwise stay in BOOT.
REQ-023 LOAD transitions: ld_start -> stays in LOAD with ld_count=0. A transfer with ld_last -> RELEASE. A transfer at ld_count=255 without ld_last -> RELEASE and ld_ovf=1. Otherwise stay in LOAD.
REQ-024 RELEASE SHALL last exactly 1 cycle, then go to RUN. ld_start arriving in RELEASE SHALL be ignored.
REQ-025 RUN transitions: ld_start -> LOAD with ld_count=0 and ld_ovf=0. Otherwise stay in RUN.
REQ-026 ld_start in BOOT SHALL clear ld_count to 0 and ld_ovf to 0.
REQ-027 ld_ready SHALL be the combinational value (state==LOAD & ~ld_start). A transfer is ld_valid & ld_ready.
REQ-028 On a transfer, in the same cycle: mem_we=1, mem_adr=ld_count, mem_wdata=ld_data. ld_count SHALL increment by 1 (mod 256) on the next cycle.
REQ-029 In LOAD with no transfer: mem_we=0 and mem_adr=ld_count.
REQ-030 In RUN, combinationally: mem_adr=core_adr, mem_we=core_memwrite, mem_wdata={7'b0,core_wdata}.
REQ-031 In BOOT and RELEASE: mem_adr=0, mem_we=0, mem_wdata=0.
REQ-032 core_reset SHALL be 1 in every state except RUN. core_memwrite SHALL be ignored outside RUN.
REQ-033 running SHALL be registered and equal (state==RUN).
REQ-034 ld_ovf SHALL remain set until the next ld_start or reset.

Reset
REQ-035 When reset is sampled high: state=BOOT, ld_count=0, ld_ovf=0, core_reset=1, running=0, ld_ready=0, mem_we=0.
REQ-036 Reset SHALL override every other input in the same cycle, including reset asserted mid-LOAD. Any in-flight transfer in that cycle SHALL be dropped (mem_we=0).

Structure
REQ-037 A shared package SHALL hold: the state enum (BOOT, LOAD, RELEASE, RUN), INSTR_W=15, ADR_W=8, IMEM_DEPTH=256.
REQ-038 A single sub-module ld_counter SHALL implement the 8-bit enabled, synchronously clearable counter with a wrap output. It SHALL be built on the team's ph1/ph2 flop style.
REQ-039 All state SHALL use ph2-capture/ph1-launch latch pairs. There SHALL be no other clocks.

Verification
REQ-040 Load-then-run: reset; ld_start; 3 words 0x1234, 0x0055, 0x7FFF, the last with ld_last.
- Writes required at addr 0, 1, 2.
- Then RELEASE for 1 cycle, RUN with core_reset=0 and ld_count=3.
REQ-041 Backpressure: ld_start and ld_valid asserted in the same cycle.
- Required: ld_ready=0, no write, ld_count=0.
- The next cycle's valid word is written at addr 0.
REQ-042 Overflow: 256 words loaded, none with ld_last.
- The final word is written at addr 255.
- Then ld_ovf=1, ld_count=0, RELEASE, RUN.
REQ-043 Run mux: in RUN drive core_adr=0x3C, core_memwrite=1, core_wdata=0xA5.
- Required: mem_adr=0x3C, mem_we=1, mem_wdata=0x00A5.
- The same stimulus in BOOT gives mem_we=0.
REQ-044 Reload and reset: ld_start in RUN -> LOAD, core_reset=1, ld_ovf=0.
- Reset after 2 words -> BOOT, ld_count=0.
REQ-045 Bypass: run_en=1 with no load -> RELEASE, then RUN, with ld_count=0.
